// File: rtl/uart_i2c_cmd_parser.sv
// rtl/uart_i2c_cmd_parser.sv - host command byte parser issuing I2C register read/write transactions
// Optional feature macro: CMD_TIMEOUT_EN (drop a partial command after BYTE_TIMEOUT idle cycles)
module uart_i2c_cmd_parser #(
   parameter int READ_BYTES   = 2,
   parameter int POLL_CYCLES  = 50000,
   parameter int BYTE_TIMEOUT = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   output logic [6:0] m_axis_cmd_address,
   output logic       m_axis_cmd_start,
   output logic       m_axis_cmd_read,
   output logic       m_axis_cmd_write,
   output logic       m_axis_cmd_stop,
   output logic       m_axis_cmd_valid,
   input  logic       m_axis_cmd_ready,
   output logic [7:0] m_axis_data_tdata,
   output logic       m_axis_data_tvalid,
   input  logic       m_axis_data_tready,
   input  logic [7:0] s_axis_data_tdata,
   input  logic       s_axis_data_tvalid,
   output logic       s_axis_data_tready,
   output logic [7:0] m_axis_tx_tdata,
   output logic       m_axis_tx_tvalid,
   input  logic       m_axis_tx_tready,
   output logic       busy,
   output logic       conv_active,
   output logic       err_timeout
);

   localparam int KW = (READ_BYTES > 1) ? $clog2(READ_BYTES) : 1;
   localparam int PW = $clog2(POLL_CYCLES + 1);
   localparam logic [KW-1:0] K_LAST = KW'(READ_BYTES - 1);
   localparam logic [PW-1:0] P_LAST = PW'(POLL_CYCLES - 1);
   localparam logic [PW-1:0] P_MAX  = PW'(POLL_CYCLES);

   if (READ_BYTES < 1 || READ_BYTES > 8 || POLL_CYCLES < 1 || BYTE_TIMEOUT < 1) begin : g_param_check
      $error("uart_i2c_cmd_parser: parameter out of range");
   end

   // PTR_DAT / WDAT_DAT carry the data beat that follows each write command handshake
   typedef enum logic [3:0] {
      S_IDLE, S_GET_REG, S_GET_DATA, S_PTR, S_PTR_DAT, S_WDAT, S_WDAT_DAT,
      S_RD, S_RXB, S_TXB, S_WAIT_POLL
   } state_t;

   state_t          state_q, state_d;
   logic [6:0]      addr_q, addr_d;
   logic            rw_q, rw_d;
   logic            conv_q, conv_d;
   logic [6:0]      reg_q, reg_d;
   logic [7:0]      wdata_q, wdata_d;
   logic [7:0]      rxb_q, rxb_d;
   logic [KW-1:0]   k_q, k_d;
   logic [PW-1:0]   poll_q, poll_d;

`ifdef CMD_TIMEOUT_EN
   localparam int TW = $clog2(BYTE_TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(BYTE_TIMEOUT - 1);
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            err_q, err_d;
   assign err_timeout = err_q;
`else
   assign err_timeout = 1'b0;
`endif

   assign busy               = (state_q != S_IDLE);
   assign conv_active        = conv_q;
   assign m_axis_cmd_address = addr_q;
   assign m_axis_tx_tdata    = rxb_q;

   // Next-state, datapath and handshake outputs for the command sequencer
   always_comb begin
      state_d            = state_q;
      addr_d             = addr_q;
      rw_d               = rw_q;
      conv_d             = conv_q;
      reg_d              = reg_q;
      wdata_d            = wdata_q;
      rxb_d              = rxb_q;
      k_d                = k_q;
      poll_d             = poll_q;
      s_axis_tready      = 1'b0;
      m_axis_cmd_start   = 1'b0;
      m_axis_cmd_read    = 1'b0;
      m_axis_cmd_write   = 1'b0;
      m_axis_cmd_stop    = 1'b0;
      m_axis_cmd_valid   = 1'b0;
      m_axis_data_tdata  = 8'h00;
      m_axis_data_tvalid = 1'b0;
      s_axis_data_tready = 1'b0;
      m_axis_tx_tvalid   = 1'b0;
`ifdef CMD_TIMEOUT_EN
      tmo_d              = '0;
      err_d              = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) begin
               addr_d  = s_axis_tdata[7:1];
               rw_d    = s_axis_tdata[0];
               state_d = S_GET_REG;
            end
         end
         S_GET_REG: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) begin
               reg_d   = s_axis_tdata[6:0];
               conv_d  = rw_q & s_axis_tdata[7];
               state_d = rw_q ? S_PTR : S_GET_DATA;
            end
`ifdef CMD_TIMEOUT_EN
            else if (tmo_q == T_LAST) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
`endif
         end
         S_GET_DATA: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) begin
               wdata_d = s_axis_tdata;
               state_d = S_PTR;
            end
`ifdef CMD_TIMEOUT_EN
            else if (tmo_q == T_LAST) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
`endif
         end
         S_PTR: begin
            m_axis_cmd_valid = 1'b1;
            m_axis_cmd_start = 1'b1;
            m_axis_cmd_write = 1'b1;
            if (m_axis_cmd_ready) state_d = S_PTR_DAT;
         end
         S_PTR_DAT: begin
            m_axis_data_tvalid = 1'b1;
            m_axis_data_tdata  = {1'b0, reg_q};
            if (m_axis_data_tready) state_d = rw_q ? S_RD : S_WDAT;
         end
         S_WDAT: begin
            m_axis_cmd_valid = 1'b1;
            m_axis_cmd_write = 1'b1;
            m_axis_cmd_stop  = 1'b1;
            if (m_axis_cmd_ready) state_d = S_WDAT_DAT;
         end
         S_WDAT_DAT: begin
            m_axis_data_tvalid = 1'b1;
            m_axis_data_tdata  = wdata_q;
            if (m_axis_data_tready) state_d = S_IDLE;
         end
         S_RD: begin
            m_axis_cmd_valid = 1'b1;
            m_axis_cmd_read  = 1'b1;
            m_axis_cmd_start = (k_q == '0);
            m_axis_cmd_stop  = (k_q == K_LAST);
            if (m_axis_cmd_ready) state_d = S_RXB;
         end
         S_RXB: begin
            s_axis_data_tready = 1'b1;
            if (s_axis_data_tvalid) begin
               rxb_d   = s_axis_data_tdata;
               state_d = S_TXB;
            end
         end
         S_TXB: begin
            m_axis_tx_tvalid = 1'b1;
            if (m_axis_tx_tready) begin
               if (k_q == K_LAST) begin
                  k_d     = '0;
                  poll_d  = '0;
                  state_d = conv_q ? S_WAIT_POLL : S_IDLE;
               end else begin
                  k_d     = k_q + 1'b1;
                  state_d = S_RD;
               end
            end
         end
         S_WAIT_POLL: begin
            // Any host byte here (including one that arrived mid-read) stops the loop
            s_axis_tready = 1'b1;
            poll_d        = (poll_q == P_MAX) ? poll_q : poll_q + 1'b1;
            if (s_axis_tvalid) begin
               conv_d  = 1'b0;
               state_d = S_IDLE;
            end else if (poll_q == P_LAST) begin
               state_d = S_PTR;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rw_q    <= 1'b0;
         conv_q  <= 1'b0;
         reg_q   <= '0;
         wdata_q <= '0;
         rxb_q   <= '0;
         k_q     <= '0;
         poll_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rw_q    <= rw_d;
         conv_q  <= conv_d;
         reg_q   <= reg_d;
         wdata_q <= wdata_d;
         rxb_q   <= rxb_d;
         k_q     <= k_d;
         poll_q  <= poll_d;
      end
   end

`ifdef CMD_TIMEOUT_EN
   // Inter-byte idle counter and one-cycle timeout pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end
`endif

endmodule

// File: tb/tb_uart_i2c_cmd_parser.sv
// tb/tb_uart_i2c_cmd_parser.sv - scoreboard bench for uart_i2c_cmd_parser
module tb_uart_i2c_cmd_parser;

   localparam int READ_BYTES   = 2;
   localparam int POLL_CYCLES  = 100;
   localparam int BYTE_TIMEOUT = 200;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s_tdata = '0;
   logic       s_tvalid = 1'b0;
   logic       s_tready;
   logic [6:0] cmd_addr;
   logic       cmd_start, cmd_read, cmd_write, cmd_stop, cmd_valid;
   logic       cmd_ready = 1'b1;
   logic [7:0] dat_tdata;
   logic       dat_tvalid;
   logic       dat_tready = 1'b1;
   logic [7:0] rd_tdata = '0;
   logic       rd_tvalid = 1'b0;
   logic       rd_tready;
   logic [7:0] tx_tdata;
   logic       tx_tvalid;
   logic       tx_ready = 1'b1;
   logic       busy, conv_active, err_timeout;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int last_tx_edge = 0;
   int ptr_edge = 0;
   int byte_edge = 0;
   int tx_left = 0;

   logic [10:0] exp_cmd[$];
   logic [7:0]  exp_dat[$];
   logic [7:0]  exp_tx[$];
   logic [7:0]  rd_resp[$];

   uart_i2c_cmd_parser #(
      .READ_BYTES(READ_BYTES), .POLL_CYCLES(POLL_CYCLES), .BYTE_TIMEOUT(BYTE_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .m_axis_cmd_address(cmd_addr), .m_axis_cmd_start(cmd_start), .m_axis_cmd_read(cmd_read),
      .m_axis_cmd_write(cmd_write), .m_axis_cmd_stop(cmd_stop), .m_axis_cmd_valid(cmd_valid),
      .m_axis_cmd_ready(cmd_ready),
      .m_axis_data_tdata(dat_tdata), .m_axis_data_tvalid(dat_tvalid), .m_axis_data_tready(dat_tready),
      .s_axis_data_tdata(rd_tdata), .s_axis_data_tvalid(rd_tvalid), .s_axis_data_tready(rd_tready),
      .m_axis_tx_tdata(tx_tdata), .m_axis_tx_tvalid(tx_tvalid), .m_axis_tx_tready(tx_ready),
      .busy(busy), .conv_active(conv_active), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: pop expectations on every handshake seen at the falling edge
   initial begin : monitor
      logic [10:0] obs, expv;
      logic prev_cv;
      prev_cv = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (cmd_valid && !prev_cv && cmd_start && cmd_write) ptr_edge = cyc;
            prev_cv = cmd_valid;
            if (cmd_valid && cmd_ready) begin
               obs = {cmd_addr, cmd_start, cmd_read, cmd_write, cmd_stop};
               n_cmp++;
               if (exp_cmd.size() == 0) begin
                  n_bad++;
                  $display("FAIL cmd_unexpected got=%h expected=none", obs);
               end else begin
                  expv = exp_cmd.pop_front();
                  if (obs !== expv) begin
                     n_bad++;
                     $display("FAIL cmd got=%h expected=%h", obs, expv);
                  end
               end
            end
            if (dat_tvalid && dat_tready) begin
               n_cmp++;
               if (exp_dat.size() == 0) begin
                  n_bad++;
                  $display("FAIL wdata_unexpected got=%h expected=none", dat_tdata);
               end else begin
                  expv = {3'b000, exp_dat.pop_front()};
                  if ({3'b000, dat_tdata} !== expv) begin
                     n_bad++;
                     $display("FAIL wdata got=%h expected=%h", dat_tdata, expv[7:0]);
                  end
               end
            end
            if (tx_tvalid && tx_ready) begin
               n_cmp++;
               last_tx_edge = cyc + 1;
               if (exp_tx.size() == 0) begin
                  n_bad++;
                  $display("FAIL tx_unexpected got=%h expected=none", tx_tdata);
               end else begin
                  expv = {3'b000, exp_tx.pop_front()};
                  if ({3'b000, tx_tdata} !== expv) begin
                     n_bad++;
                     $display("FAIL tx got=%h expected=%h", tx_tdata, expv[7:0]);
                  end
               end
            end
         end else begin
            prev_cv = 1'b0;
         end
      end
   end

   // I2C master model: answers each read command with the next queued byte
   initial begin : i2c_model
      forever begin
         @(negedge clk);
         if (!rst && cmd_valid && cmd_ready && cmd_read) begin
            @(posedge clk); #1;
            rd_tdata  = (rd_resp.size() > 0) ? rd_resp.pop_front() : 8'hEE;
            rd_tvalid = 1'b1;
            for (int i = 0; i < 1000; i++) begin
               @(negedge clk);
               if (rd_tready) break;
            end
            @(posedge clk); #1;
            rd_tvalid = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic push_read(input logic [6:0] a, input logic [6:0] r, input logic [7:0] b0, input logic [7:0] b1);
      exp_cmd.push_back({a, 1'b1, 1'b0, 1'b1, 1'b0});
      exp_dat.push_back({1'b0, r});
      exp_cmd.push_back({a, 1'b1, 1'b1, 1'b0, 1'b0});
      exp_cmd.push_back({a, 1'b0, 1'b1, 1'b0, 1'b1});
      rd_resp.push_back(b0);
      rd_resp.push_back(b1);
      exp_tx.push_back(b0);
      exp_tx.push_back(b1);
   endtask

   task automatic push_write(input logic [6:0] a, input logic [6:0] r, input logic [7:0] d);
      exp_cmd.push_back({a, 1'b1, 1'b0, 1'b1, 1'b0});
      exp_dat.push_back({1'b0, r});
      exp_cmd.push_back({a, 1'b0, 1'b0, 1'b1, 1'b1});
      exp_dat.push_back(d);
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit done;
      done = 1'b0;
      s_tdata  = b;
      s_tvalid = 1'b1;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(negedge clk);
         if (s_tready) begin
            done      = 1'b1;
            byte_edge = cyc + 1;
            tx_left   = exp_tx.size();
         end
      end
      @(posedge clk); #1;
      s_tvalid = 1'b0;
      n_cmp++;
      if (!done) begin
         n_bad++;
         $display("FAIL send_byte byte=%h got=no_ready expected=ready", b);
      end
   endtask

   task automatic wait_idle(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         if (!busy && exp_cmd.size() == 0 && exp_dat.size() == 0 && exp_tx.size() == 0) done = 1'b1;
      end
      @(posedge clk); #1;
      n_cmp++;
      if (!done) begin
         n_bad++;
         $display("FAIL %s_idle got=busy%0d/cmd%0d/tx%0d expected=idle/0/0", name, busy, exp_cmd.size(), exp_tx.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (s_tready !== 1'b1) begin
         n_bad++; $display("FAIL reset_tready got=%b expected=1", s_tready);
      end
      n_cmp++;
      if ({cmd_valid, dat_tvalid, tx_tvalid, rd_tready} !== 4'b0000) begin
         n_bad++; $display("FAIL reset_valids got=%b expected=0000", {cmd_valid, dat_tvalid, tx_tvalid, rd_tready});
      end
      n_cmp++;
      if ({busy, conv_active, err_timeout} !== 3'b000) begin
         n_bad++; $display("FAIL reset_status got=%b expected=000", {busy, conv_active, err_timeout});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single_read();
      push_read(7'h34, 7'h14, 8'hAB, 8'hCD);
      send_byte(8'h69);
      send_byte(8'h14);
      wait_idle("single_read");
      n_cmp++;
      if ({conv_active, s_tready} !== 2'b01) begin
         n_bad++; $display("FAIL single_read_end got=%b expected=01", {conv_active, s_tready});
      end
   endtask

   task automatic test_write();
      push_write(7'h34, 7'h3B, 8'h5A);
      send_byte(8'h68);
      send_byte(8'h3B);
      send_byte(8'h5A);
      wait_idle("write");
   endtask

   task automatic test_conversion();
      bit seen;
      int t1;
      push_read(7'h34, 7'h14, 8'h11, 8'h22);
      push_read(7'h34, 7'h14, 8'h33, 8'h44);
      send_byte(8'h69);
      send_byte(8'h94);
      seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk);
         if (exp_tx.size() <= 2) seen = 1'b1;
      end
      t1 = last_tx_edge;
      @(negedge clk);
      n_cmp++;
      if (!seen || {conv_active, busy, s_tready} !== 3'b111) begin
         n_bad++; $display("FAIL conv_wait_poll got=%b expected=111", {conv_active, busy, s_tready});
      end
      seen = 1'b0;
      for (int i = 0; i < 500 && !seen; i++) begin
         @(negedge clk);
         if (ptr_edge > t1) seen = 1'b1;
      end
      n_cmp++;
      if (!seen || (ptr_edge - t1) != POLL_CYCLES) begin
         n_bad++; $display("FAIL conv_poll_period got=%0d expected=%0d", ptr_edge - t1, POLL_CYCLES);
      end
      @(posedge clk); #1;
      send_byte(8'hFF);
      n_cmp++;
      if (tx_left != 0) begin
         n_bad++; $display("FAIL conv_stop_point got=%0d expected=0", tx_left);
      end
      @(negedge clk);
      n_cmp++;
      if ({conv_active, busy} !== 2'b00) begin
         n_bad++; $display("FAIL conv_stopped got=%b expected=00", {conv_active, busy});
      end
      repeat (300) @(posedge clk);
      #1;
      wait_idle("conversion");
   endtask

   task automatic test_backpressure();
      bit seen;
      int bad;
      tx_ready = 1'b0;
      push_read(7'h34, 7'h14, 8'hAB, 8'hCD);
      send_byte(8'h69);
      send_byte(8'h14);
      seen = 1'b0;
      for (int i = 0; i < 500 && !seen; i++) begin
         @(negedge clk);
         if (tx_tvalid) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
         n_bad++; $display("FAIL bp_tx_valid got=0 expected=1");
      end
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tx_tvalid !== 1'b1 || tx_tdata !== 8'hAB || rd_tready !== 1'b0 || cmd_valid !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++; $display("FAIL bp_hold got=%0d_bad_cycles expected=0", bad);
      end
      @(posedge clk); #1;
      tx_ready = 1'b1;
      wait_idle("backpressure");
   endtask

   task automatic test_mid_reset();
      send_byte(8'h68);
      send_byte(8'h3B);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy, s_tready, cmd_valid, dat_tvalid} !== 4'b0100) begin
         n_bad++; $display("FAIL mid_reset got=%b expected=0100", {busy, s_tready, cmd_valid, dat_tvalid});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      push_read(7'h34, 7'h14, 8'h5C, 8'hA3);
      push_write(7'h21, 7'h07, 8'hC3);
      send_byte(8'h69);
      send_byte(8'h14);
      send_byte(8'h42);
      send_byte(8'h07);
      send_byte(8'hC3);
      wait_idle("back_to_back");
   endtask

`ifdef CMD_TIMEOUT_EN
   task automatic test_timeout();
      bit seen;
      int t;
      send_byte(8'h69);
      seen = 1'b0;
      t = 0;
      for (int i = 0; i < 1000 && !seen; i++) begin
         @(negedge clk);
         if (err_timeout) begin
            seen = 1'b1;
            t    = cyc;
         end
      end
      n_cmp++;
      if (!seen || (t - byte_edge) != BYTE_TIMEOUT) begin
         n_bad++; $display("FAIL timeout_delay got=%0d expected=%0d", t - byte_edge, BYTE_TIMEOUT);
      end
      @(negedge clk);
      n_cmp++;
      if ({err_timeout, busy} !== 2'b00) begin
         n_bad++; $display("FAIL timeout_pulse got=%b expected=00", {err_timeout, busy});
      end
      @(posedge clk); #1;
   endtask
`else
   task automatic test_timeout();
      int bad;
      send_byte(8'h69);
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (err_timeout !== 1'b0 || busy !== 1'b1 || cmd_valid !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++; $display("FAIL wait_forever got=%0d_bad_cycles expected=0", bad);
      end
      @(posedge clk); #1;
      push_read(7'h34, 7'h14, 8'h12, 8'h34);
      send_byte(8'h14);
      wait_idle("late_reg");
   endtask
`endif

   initial begin : main
      test_reset();
      test_single_read();
      test_write();
      test_conversion();
      test_backpressure();
      test_mid_reset();
      test_back_to_back();
      test_timeout();
      n_cmp++;
      if (exp_cmd.size() != 0 || exp_dat.size() != 0 || exp_tx.size() != 0) begin
         n_bad++;
         $display("FAIL leftover got=cmd%0d/dat%0d/tx%0d expected=0/0/0", exp_cmd.size(), exp_dat.size(), exp_tx.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
